// File: rtl/prog_loader.sv
// Byte-stream program loader: parses command/address/length headers and writes
// instruction words or data bytes, holding the core in reset until end-of-load.
module prog_loader #(
  parameter int INST_ADDR_W = 8,
  parameter int DATA_ADDR_W = 8
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   in_valid,
  input  logic [7:0]             in_data,
  output logic                   in_ready,
  output logic                   inst_we,
  output logic [INST_ADDR_W-1:0] inst_addr,
  output logic [31:0]            inst_wdata,
  output logic                   data_we,
  output logic [DATA_ADDR_W-1:0] data_addr,
  output logic [7:0]             data_wdata,
  output logic                   core_rst,
  output logic                   load_done,
  output logic                   load_error
);

  localparam int AW = (INST_ADDR_W > DATA_ADDR_W) ? INST_ADDR_W : DATA_ADDR_W;

  localparam logic [7:0] CMD_INST = 8'h01;
  localparam logic [7:0] CMD_DATA = 8'h02;
  localparam logic [7:0] CMD_END  = 8'hFF;

  typedef enum logic [2:0] {
    S_CMD, S_ADDR_LO, S_ADDR_HI, S_LEN_LO, S_LEN_HI, S_PAYLOAD, S_DONE, S_ERROR
  } state_e;

  state_e                 state_q, state_d;
  logic                   is_inst_q, is_inst_d;
  logic [AW-1:0]          addr_q, addr_d;
  logic [15:0]            len_q, len_d;
  logic [1:0]             idx_q, idx_d;
  logic [23:0]            word_q, word_d;

  logic                   in_ready_q, in_ready_d;
  logic                   inst_we_q, inst_we_d;
  logic [INST_ADDR_W-1:0] inst_addr_q, inst_addr_d;
  logic [31:0]            inst_wdata_q, inst_wdata_d;
  logic                   data_we_q, data_we_d;
  logic [DATA_ADDR_W-1:0] data_addr_q, data_addr_d;
  logic [7:0]             data_wdata_q, data_wdata_d;
  logic                   core_rst_q, core_rst_d;
  logic                   load_done_q, load_done_d;
  logic                   load_error_q, load_error_d;

  logic                   accept;
  logic                   wr_fire;

  assign accept = in_valid & in_ready_q;

  // NOTE: sequential state uses non-blocking assignments only, so every flop
  // samples the pre-edge value of every other flop regardless of statement order.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= S_CMD;
      is_inst_q    <= 1'b0;
      addr_q       <= '0;
      len_q        <= '0;
      idx_q        <= '0;
      word_q       <= '0;
      in_ready_q   <= 1'b0;
      inst_we_q    <= 1'b0;
      inst_addr_q  <= '0;
      inst_wdata_q <= '0;
      data_we_q    <= 1'b0;
      data_addr_q  <= '0;
      data_wdata_q <= '0;
      core_rst_q   <= 1'b1;
      load_done_q  <= 1'b0;
      load_error_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      is_inst_q    <= is_inst_d;
      addr_q       <= addr_d;
      len_q        <= len_d;
      idx_q        <= idx_d;
      word_q       <= word_d;
      in_ready_q   <= in_ready_d;
      inst_we_q    <= inst_we_d;
      inst_addr_q  <= inst_addr_d;
      inst_wdata_q <= inst_wdata_d;
      data_we_q    <= data_we_d;
      data_addr_q  <= data_addr_d;
      data_wdata_q <= data_wdata_d;
      core_rst_q   <= core_rst_d;
      load_done_q  <= load_done_d;
      load_error_q <= load_error_d;
    end
  end

  // NOTE: every variable assigned below gets a default first; otherwise a path
  // that skips an assignment would infer a latch.
  always_comb begin
    state_d   = state_q;
    is_inst_d = is_inst_q;
    addr_d    = addr_q;
    len_d     = len_q;
    idx_d     = idx_q;
    word_d    = word_q;
    wr_fire   = 1'b0;

    case (state_q)
      S_CMD: begin
        if (accept) begin
          if (in_data == CMD_INST) begin
            is_inst_d = 1'b1;
            state_d   = S_ADDR_LO;
          end else if (in_data == CMD_DATA) begin
            is_inst_d = 1'b0;
            state_d   = S_ADDR_LO;
          end else if (in_data == CMD_END) begin
            state_d = S_DONE;
          end else begin
            state_d = S_ERROR;
          end
        end
      end
      S_ADDR_LO: if (accept) begin
        addr_d  = AW'(in_data);
        state_d = S_ADDR_HI;
      end
      // Only the low AW bits of the 16-bit start address survive.
      S_ADDR_HI: if (accept) begin
        addr_d  = AW'({in_data, addr_q[7:0]});
        state_d = S_LEN_LO;
      end
      S_LEN_LO: if (accept) begin
        len_d   = {8'h00, in_data};
        state_d = S_LEN_HI;
      end
      S_LEN_HI: if (accept) begin
        len_d   = {in_data, len_q[7:0]};
        idx_d   = 2'd0;
        state_d = (len_d == 16'd0) ? S_CMD : S_PAYLOAD;
      end
      S_PAYLOAD: begin
        if (accept) begin
          if (is_inst_q) begin
            idx_d   = idx_q + 2'd1;
            word_d  = {in_data, word_q[23:8]};
            wr_fire = (idx_q == 2'd3);
          end else begin
            wr_fire = 1'b1;
          end
          if (wr_fire) begin
            addr_d = addr_q + AW'(1);
            len_d  = len_q - 16'd1;
            if (len_q == 16'd1) state_d = S_CMD;
          end
        end
      end
      S_DONE:  state_d = S_DONE;
      S_ERROR: state_d = S_ERROR;
      default: state_d = S_ERROR;
    endcase
  end

  // Registered outputs follow the upcoming state so they line up with it.
  always_comb begin
    in_ready_d   = (state_d != S_DONE) && (state_d != S_ERROR);
    load_done_d  = (state_d == S_DONE);
    load_error_d = (state_d == S_ERROR);
    core_rst_d   = (state_d != S_DONE);

    inst_we_d    = wr_fire & is_inst_q;
    inst_addr_d  = inst_addr_q;
    inst_wdata_d = inst_wdata_q;
    data_we_d    = wr_fire & ~is_inst_q;
    data_addr_d  = data_addr_q;
    data_wdata_d = data_wdata_q;

    if (inst_we_d) begin
      inst_addr_d  = addr_q[INST_ADDR_W-1:0];
      inst_wdata_d = {in_data, word_q};
    end
    if (data_we_d) begin
      data_addr_d  = addr_q[DATA_ADDR_W-1:0];
      data_wdata_d = in_data;
    end
  end

  assign in_ready   = in_ready_q;
  assign inst_we    = inst_we_q;
  assign inst_addr  = inst_addr_q;
  assign inst_wdata = inst_wdata_q;
  assign data_we    = data_we_q;
  assign data_addr  = data_addr_q;
  assign data_wdata = data_wdata_q;
  assign core_rst   = core_rst_q;
  assign load_done  = load_done_q;
  assign load_error = load_error_q;

endmodule

// File: tb/tb_prog_loader.sv
// Bench for prog_loader: a stream parser predicts the write sequence, a monitor
// compares every strobe against it, and literal checks pin key results.
module tb_prog_loader;

  logic       clk = 1'b0;
  logic       rst;
  logic       in_valid;
  logic [7:0] in_data;
  logic       in_ready;
  logic       inst_we;
  logic [7:0] inst_addr;
  logic [31:0] inst_wdata;
  logic       data_we;
  logic [7:0] data_addr;
  logic [7:0] data_wdata;
  logic       core_rst;
  logic       load_done;
  logic       load_error;

  prog_loader #(.INST_ADDR_W(8), .DATA_ADDR_W(8)) dut (
    .clk        (clk),
    .rst        (rst),
    .in_valid   (in_valid),
    .in_data    (in_data),
    .in_ready   (in_ready),
    .inst_we    (inst_we),
    .inst_addr  (inst_addr),
    .inst_wdata (inst_wdata),
    .data_we    (data_we),
    .data_addr  (data_addr),
    .data_wdata (data_wdata),
    .core_rst   (core_rst),
    .load_done  (load_done),
    .load_error (load_error)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic        is_inst;
    logic [7:0]  addr;
    logic [31:0] data;
  } wr_t;

  wr_t exp_q[$];
  wr_t act_log[$];
  int  n_tests = 0;
  int  n_fail  = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Reference: walk the byte stream by its format rules and list every write.
  task automatic parse(input logic [7:0] b[$], output bit done, output bit err);
    int i = 0;
    int n = b.size();
    logic [15:0] addr, len;
    done = 0;
    err  = 0;
    while (i < n) begin
      logic [7:0] c = b[i];
      i++;
      if (c == 8'hFF) begin done = 1; return; end
      if (c != 8'h01 && c != 8'h02) begin err = 1; return; end
      if (i + 4 > n) return;
      addr = {b[i+1], b[i]};
      len  = {b[i+3], b[i+2]};
      i += 4;
      for (int k = 0; k < int'(len); k++) begin
        wr_t w;
        w.is_inst = (c == 8'h01);
        w.addr    = 8'((int'(addr) + k) % 256);
        if (w.is_inst) begin
          if (i + 4 > n) return;
          w.data = {b[i+3], b[i+2], b[i+1], b[i]};
          i += 4;
        end else begin
          if (i + 1 > n) return;
          w.data = {24'h0, b[i]};
          i += 1;
        end
        exp_q.push_back(w);
      end
    end
  endtask

  // Monitor: every strobe must match the next predicted write.
  always @(negedge clk) begin
    if (rst === 1'b0) begin
      check("core_rst_vs_done", core_rst, !load_done);
      if (inst_we || data_we) begin
        wr_t a;
        check("one_strobe", inst_we & data_we, 0);
        a = inst_we ? {1'b1, inst_addr, inst_wdata} : {1'b0, data_addr, 24'h0, data_wdata};
        act_log.push_back(a);
        if (exp_q.size() == 0) check("unexpected_write", exp_q.size(), 1);
        else check("write", a, exp_q.pop_front());
      end
    end
  end

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    in_valid = 1'b0;
    @(posedge clk);
    @(negedge clk);
    check("rst_in_ready", in_ready, 0);
    check("rst_core_rst", core_rst, 1);
    check("rst_we", {inst_we, data_we}, 0);
    check("rst_flags", {load_done, load_error}, 0);
    check("rst_addr_data", {inst_addr, inst_wdata, data_addr, data_wdata}, 0);
    exp_q.delete();
    act_log.delete();
    rst = 1'b0;
    @(posedge clk);
    @(negedge clk);
    check("in_ready_after_rst", in_ready, 1);
  endtask

  // Handshaked send; called at a negedge, returns at a negedge.
  task automatic send(input logic [7:0] b[$], input int gap);
    foreach (b[i]) begin
      int waited = 0;
      in_valid = 1'b1;
      in_data  = b[i];
      while (!in_ready && waited < 20) begin
        @(negedge clk);
        waited++;
      end
      if (!in_ready) begin
        check("ready_timeout", waited, 0);
        in_valid = 1'b0;
        return;
      end
      @(posedge clk);
      @(negedge clk);
      in_valid = 1'b0;
      repeat (gap) @(negedge clk);
    end
  endtask

  // Presents bytes for one cycle each without waiting for in_ready.
  task automatic send_raw(input logic [7:0] b[$]);
    foreach (b[i]) begin
      in_valid = 1'b1;
      in_data  = b[i];
      @(negedge clk);
    end
    in_valid = 1'b0;
  endtask

  task automatic finish_checks(input string tag, input bit done, input bit err);
    idle(3);
    check({tag, "_pending"}, exp_q.size(), 0);
    check({tag, "_done"}, load_done, done);
    check({tag, "_error"}, load_error, err);
    check({tag, "_core_rst"}, core_rst, !done);
    check({tag, "_in_ready"}, in_ready, !(done || err));
  endtask

  logic [7:0] s[$];
  bit         m_done, m_err;

  initial begin
    rst = 1'b1;
    in_valid = 1'b0;
    in_data = 8'h00;
    idle(2);

    // Two instruction words
    do_reset();
    s = '{8'h01, 8'h00, 8'h00, 8'h02, 8'h00,
          8'h13, 8'h05, 8'hA0, 8'h00, 8'hB3, 8'h05, 8'hB5, 8'h00};
    parse(s, m_done, m_err);
    send(s, 0);
    finish_checks("t1", m_done, m_err);
    check("t1_count", act_log.size(), 2);
    check("t1_w0", act_log[0], {1'b1, 8'h00, 32'h00A00513});
    check("t1_w1", act_log[1], {1'b1, 8'h01, 32'h00B505B3});

    // Data block then end-of-load; flags must flip the cycle after 0xFF
    s = '{8'h02, 8'h08, 8'h00, 8'h03, 8'h00, 8'hAA, 8'hBB, 8'hCC, 8'hFF};
    parse(s, m_done, m_err);
    send(s, 0);
    check("t2_done_next", load_done, 1);
    check("t2_core_rst_next", core_rst, 0);
    check("t2_in_ready_next", in_ready, 0);
    send_raw('{8'h02, 8'h00, 8'h00, 8'h01, 8'h00, 8'h77});
    finish_checks("t2", m_done, m_err);
    check("t2_count", act_log.size(), 5);
    check("t2_w2", act_log[4], {1'b0, 8'd10, 32'h0000_00CC});

    // Address wrap and truncation
    do_reset();
    s = '{8'h02, 8'hFF, 8'h00, 8'h02, 8'h00, 8'h11, 8'h22,
          8'h02, 8'hFE, 8'h01, 8'h01, 8'h00, 8'h33};
    parse(s, m_done, m_err);
    send(s, 0);
    finish_checks("t3", m_done, m_err);
    check("t3_w0", act_log[0], {1'b0, 8'd255, 32'h0000_0011});
    check("t3_w1", act_log[1], {1'b0, 8'd0,   32'h0000_0022});
    check("t3_w2", act_log[2], {1'b0, 8'd254, 32'h0000_0033});

    // Stalls between bytes and a zero-length block
    do_reset();
    s = '{8'h01, 8'h10, 8'h00, 8'h01, 8'h00, 8'hEF, 8'hBE, 8'hAD, 8'hDE,
          8'h01, 8'h05, 8'h00, 8'h00, 8'h00,
          8'h02, 8'h03, 8'h00, 8'h01, 8'h00, 8'h5A};
    parse(s, m_done, m_err);
    send(s, 1);
    finish_checks("t4", m_done, m_err);
    check("t4_count", act_log.size(), 2);
    check("t4_w0", act_log[0], {1'b1, 8'h10, 32'hDEADBEEF});
    check("t4_w1", act_log[1], {1'b0, 8'h03, 32'h0000_005A});

    // Illegal command locks up with the core held in reset
    do_reset();
    s = '{8'h07};
    parse(s, m_done, m_err);
    send(s, 0);
    send_raw('{8'h02, 8'h00, 8'h00, 8'h01, 8'h00, 8'h99});
    finish_checks("t5", m_done, m_err);
    check("t5_error_lit", load_error, 1);
    check("t5_count", act_log.size(), 0);

    // Reset in the middle of an instruction word, then a clean reload
    do_reset();
    s = '{8'h01, 8'h00, 8'h00, 8'h01, 8'h00, 8'h13, 8'h05};
    parse(s, m_done, m_err);
    send(s, 0);
    idle(1);
    check("t6_no_partial", act_log.size(), 0);
    do_reset();
    s = '{8'h01, 8'h03, 8'h00, 8'h01, 8'h00, 8'h78, 8'h56, 8'h34, 8'h12, 8'hFF};
    parse(s, m_done, m_err);
    send(s, 0);
    finish_checks("t6", m_done, m_err);
    check("t6_count", act_log.size(), 1);
    check("t6_w0", act_log[0], {1'b1, 8'h03, 32'h12345678});

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1, "timeout");
  end

endmodule
